// File: rtl/cond_unit_if.sv
// Instruction-side bundle for cond_unit: decoder intents and ALU flags in,
// gated write enables, condition result, flags and statistics out.
interface cond_unit_if #(
  parameter int CNT_W = 16
);
  logic             valid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             CondUndef;
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SquashCnt;

  modport master (
    output valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, CondUndef, ExecCnt, SquashCnt
  );

  modport slave (
    input  valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, CondUndef, ExecCnt, SquashCnt
  );
endinterface

// File: rtl/cond_unit.sv
// ARMv4 conditional-execution unit: registered NZCV, zero-latency write gating.
// Execute/squash counters exist only when COND_UNIT_STATS_EN is defined.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);
  logic [3:0] flags;
  logic       undef_q;
  logic       cond_ex;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags;

  // Evaluated against the registered flags only, so a flag-setting
  // instruction never influences its own condition.
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = !z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = !c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = !n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = !v_f;
      4'b1000: cond_ex = c_f && !z_f;
      4'b1001: cond_ex = !c_f || z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = !z_f && (n_f == v_f);
      4'b1101: cond_ex = z_f || (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign bus.CondEx    = cond_ex;
  assign bus.PCSrc     = bus.PCS && cond_ex && bus.valid;
  assign bus.MemWrite  = bus.MemW && cond_ex && bus.valid;
  assign bus.RegWrite  = bus.RegW && cond_ex && bus.valid && !bus.NoWrite;
  assign bus.Flags     = flags;
  assign bus.CondUndef = undef_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags   <= 4'b0000;
      undef_q <= 1'b0;
    end else begin
      if (bus.valid && cond_ex) begin
        if (bus.FlagW[1]) flags[3:2] <= bus.ALUFlags[3:2];
        if (bus.FlagW[0]) flags[1:0] <= bus.ALUFlags[1:0];
      end
      undef_q <= bus.valid && (bus.Cond == 4'b1111);
    end
  end

`ifdef COND_UNIT_STATS_EN
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (bus.valid) begin
      if (cond_ex && (exec_cnt != '1))
        exec_cnt <= exec_cnt + 1'b1;
      if (!cond_ex && (squash_cnt != '1))
        squash_cnt <= squash_cnt + 1'b1;
    end
  end

  assign bus.ExecCnt   = exec_cnt;
  assign bus.SquashCnt = squash_cnt;
`else
  assign bus.ExecCnt   = '0;
  assign bus.SquashCnt = '0;
`endif
endmodule
